// File: rtl/cmd_mem_reader.sv
// Round-robin scanner over the command record memory: reads each slot, issues
// due commands to the pulse sequencer, then asks the writer to free the slot.
module cmd_mem_reader #(
  parameter int N_IDX  = 256,
  parameter int ADDR_W = 8,
  parameter int DW     = 338,
  parameter int RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              EN,
  input  logic [63:0]       SYS_TIME,
  output logic [ADDR_W-1:0] MEM_RDADDR,
  output logic              MEM_RDEN,
  input  logic [DW-1:0]     MEM_Q,
  output logic              CMD_VALID,
  input  logic              CMD_READY,
  output logic [DW-1:0]     CMD_DATA,
  output logic [ADDR_W-1:0] CMD_ADDR,
  output logic              FREE_REQ,
  output logic [ADDR_W-1:0] FREE_ADDR,
  input  logic              FREE_ACK,
  output logic              SCAN_WRAP,
  output logic [15:0]       ISSUE_CNT
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, ISSUE, FREE, NEXT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [DW-1:0]       rec;
  logic [RD_LAT:1]     vld_pipe;  // bit k high k cycles after the read pulse
  logic [63:0]         ts;
  logic                last_slot;
  logic                slot_due;

  assign ts        = rec[DW-1 -: 64];
  assign last_slot = (addr == ADDR_W'(N_IDX - 1));
  // an all-ones start time marks an empty slot, never due
  assign slot_due  = (ts != '1) && (ts <= SYS_TIME);

  assign MEM_RDADDR = addr;
  assign MEM_RDEN   = (state == READ);
  assign CMD_VALID  = (state == ISSUE);
  assign CMD_DATA   = rec;
  assign CMD_ADDR   = addr;
  assign FREE_REQ   = (state == FREE);
  assign FREE_ADDR  = addr;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (EN) state_nxt = READ;
      READ:    state_nxt = WAIT;
      WAIT:    if (vld_pipe[RD_LAT]) state_nxt = CHECK;
      CHECK:   state_nxt = slot_due ? ISSUE : NEXT;
      ISSUE:   if (CMD_READY) state_nxt = FREE;
      FREE:    if (FREE_ACK) state_nxt = NEXT;
      NEXT:    state_nxt = EN ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      rec       <= '0;
      vld_pipe  <= '0;
      SCAN_WRAP <= 1'b0;
      ISSUE_CNT <= '0;
    end else begin
      state       <= state_nxt;
      vld_pipe[1] <= (state == READ);
      for (int k = 2; k <= RD_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      if (state == WAIT && vld_pipe[RD_LAT]) rec <= MEM_Q;
      if (state == ISSUE && CMD_READY) ISSUE_CNT <= ISSUE_CNT + 16'd1;
      SCAN_WRAP <= (state == NEXT) && last_slot;
      if (state == NEXT) addr <= last_slot ? '0 : addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_cmd_mem_reader.sv
// Bench for cmd_mem_reader: behavioural memory + writer + sequencer, with a
// slot-order scoreboard deciding from the record contents which slots must issue.
module tb_cmd_mem_reader;
  localparam int N = 256, AW = 8, DW = 338, RD_LAT = 2;
  localparam logic [63:0] EMPTY = '1;

  logic          CLK = 1'b0;
  logic          rst, EN, CMD_READY, FREE_ACK;
  logic [63:0]   SYS_TIME;
  logic [AW-1:0] MEM_RDADDR, CMD_ADDR, FREE_ADDR;
  logic          MEM_RDEN, CMD_VALID, FREE_REQ, SCAN_WRAP;
  logic [DW-1:0] MEM_Q, CMD_DATA;
  logic [15:0]   ISSUE_CNT;

  always #5 CLK = ~CLK;

  cmd_mem_reader #(.N_IDX(N), .ADDR_W(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .rst(rst), .EN(EN), .SYS_TIME(SYS_TIME),
    .MEM_RDADDR(MEM_RDADDR), .MEM_RDEN(MEM_RDEN), .MEM_Q(MEM_Q),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DATA(CMD_DATA), .CMD_ADDR(CMD_ADDR),
    .FREE_REQ(FREE_REQ), .FREE_ADDR(FREE_ADDR), .FREE_ACK(FREE_ACK),
    .SCAN_WRAP(SCAN_WRAP), .ISSUE_CNT(ISSUE_CNT)
  );

  int checks = 0, fails = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // memory: data valid only in the single cycle RD_LAT after the read pulse
  logic [DW-1:0]   mem [N];
  logic [RD_LAT-1:0] en_d = '0;
  logic [AW-1:0]   addr_d [RD_LAT] = '{default: '0};
  always @(posedge CLK) begin
    en_d[0]   <= MEM_RDEN;
    addr_d[0] <= MEM_RDADDR;
    for (int k = 1; k < RD_LAT; k++) begin
      en_d[k]   <= en_d[k-1];
      addr_d[k] <= addr_d[k-1];
    end
  end
  assign MEM_Q = en_d[RD_LAT-1] ? mem[addr_d[RD_LAT-1]] : '0;

  function automatic logic [DW-1:0] mk_rec(input logic [63:0] ts);
    logic [351:0] r;
    for (int i = 0; i < 11; i++) r[i*32 +: 32] = $urandom;
    return {ts, r[273:0]};
  endfunction

  // sequencer and writer models
  int unsigned rdy_pct = 100;
  int unsigned ack_min = 0, ack_max = 0;
  bit spurious = 0;
  initial begin
    CMD_READY = 1'b0;
    forever begin
      @(posedge CLK); #1;
      CMD_READY = ($urandom_range(0, 99) < rdy_pct);
    end
  end
  initial begin
    int w;
    w = 0;
    FREE_ACK = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (FREE_REQ && !FREE_ACK) begin
        if (w == 0) begin
          FREE_ACK = 1'b1;
          mem[FREE_ADDR][DW-1 -: 64] = EMPTY;
        end else w--;
      end else begin
        w = int'($urandom_range(ack_min, ack_max));
        FREE_ACK = !FREE_REQ && spurious && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // scoreboard: expected scan order, due decision at the compare cycle
  int cyc = 0, chk_cd = 0, exp_cnt = 0, valid_cycles = 0, free_cycles = 0;
  logic [AW-1:0] exp_addr = '0, cur_addr = '0;
  bit rd_seen, exp_due, issued, freed, wrap_seen, prev_v, prev_r, prev_fr, prev_ack, prev_wrap;
  int hs_addr[$], hs_cyc[$], fr_addr[$], fr_cyc[$], wrap_cyc[$];
  logic [DW-1:0] hs_data[$];

  always @(negedge CLK) begin
    cyc++;
    if (rst) begin
      exp_addr = '0; rd_seen = 0; chk_cd = 0; exp_cnt = 0; issued = 0; freed = 0;
      wrap_seen = 0; prev_v = 0; prev_fr = 0; prev_wrap = 0;
    end else begin
      if (chk_cd > 0) begin
        chk_cd--;
        if (chk_cd == 0)
          exp_due = (mem[cur_addr][DW-1 -: 64] != EMPTY) && (mem[cur_addr][DW-1 -: 64] <= SYS_TIME);
      end
      if (SCAN_WRAP) begin
        chk("wrap_after_last", rd_seen && cur_addr == AW'(N-1) && chk_cd == 0, 1);
        chk("wrap_1cyc", prev_wrap, 0);
        wrap_seen = 1; wrap_cyc.push_back(cyc);
      end
      if (MEM_RDEN) begin
        if (rd_seen) begin
          chk("slot_issued", issued, exp_due);
          if (issued) chk("slot_freed", freed, 1);
          if (MEM_RDADDR == 0) chk("wrap_seen", wrap_seen, 1);
        end
        chk("rdaddr", MEM_RDADDR, exp_addr);
        chk("rden_excl", CMD_VALID | FREE_REQ, 0);
        cur_addr = MEM_RDADDR; exp_addr = MEM_RDADDR + 8'd1;
        rd_seen = 1; issued = 0; freed = 0; wrap_seen = 0; chk_cd = RD_LAT + 1;
      end
      if (prev_v && !prev_r) chk("valid_hold", CMD_VALID, 1);
      if (prev_v && prev_r) chk("valid_drop_free", {CMD_VALID, FREE_REQ}, 2'b01);
      if (prev_fr && !prev_ack) chk("free_hold", FREE_REQ, 1);
      if (prev_fr && prev_ack) chk("free_drop", FREE_REQ, 0);
      if (CMD_VALID) begin
        valid_cycles++;
        chk("valid_due", rd_seen && chk_cd == 0 && exp_due && !issued, 1);
        chk("cmd_addr", CMD_ADDR, cur_addr);
        chk("cmd_data", CMD_DATA, mem[cur_addr]);
        if (CMD_READY) begin
          chk("issue_cnt", ISSUE_CNT, exp_cnt[15:0]);
          exp_cnt++; issued = 1;
          hs_addr.push_back(int'(CMD_ADDR)); hs_data.push_back(CMD_DATA); hs_cyc.push_back(cyc);
        end
      end
      if (FREE_REQ) begin
        free_cycles++;
        chk("free_addr", FREE_ADDR, cur_addr);
        chk("free_after_issue", issued, 1);
        if (FREE_ACK) begin
          freed = 1; fr_addr.push_back(int'(FREE_ADDR)); fr_cyc.push_back(cyc);
        end
      end
      prev_v = CMD_VALID; prev_r = CMD_READY; prev_fr = FREE_REQ;
      prev_ack = FREE_ACK; prev_wrap = SCAN_WRAP;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic quiesce();
    EN = 1'b0;
    tick(RD_LAT + 8);
  endtask

  task automatic wait_wrap(input string tag);
    int n0 = wrap_cyc.size();
    for (int k = 0; k < 3000 && wrap_cyc.size() == n0; k++) tick(1);
    if (wrap_cyc.size() == n0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_hs(input int target, input string tag);
    for (int k = 0; k < 3000 && hs_addr.size() < target; k++) tick(1);
    if (hs_addr.size() < target) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_fr(input int target, input string tag);
    for (int k = 0; k < 3000 && fr_addr.size() < target; k++) tick(1);
    if (fr_addr.size() < target) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input int a, input string tag);
    int k;
    for (k = 0; k < 3000 && !(CMD_VALID && CMD_ADDR == AW'(a)); k++) tick(1);
    if (k == 3000) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [DW-1:0] r5, r3;
    int n0, m0, f0;
    rst = 1'b1; EN = 1'b0; SYS_TIME = '0;
    for (int i = 0; i < N; i++) mem[i] = mk_rec(EMPTY);
    tick(3);
    chk("rst_rden", MEM_RDEN, 0);       chk("rst_valid", CMD_VALID, 0);
    chk("rst_freereq", FREE_REQ, 0);    chk("rst_wrap", SCAN_WRAP, 0);
    chk("rst_cnt", ISSUE_CNT, 0);       chk("rst_data", CMD_DATA, 0);
    chk("rst_caddr", CMD_ADDR, 0);      chk("rst_faddr", FREE_ADDR, 0);
    chk("rst_rdaddr", MEM_RDADDR, 0);
    rst = 1'b0; EN = 1'b1;

    // all empty: fixed 5-cycle slot period, no commands
    wait_wrap("p1_w0");
    wait_wrap("p1_w1");
    if (wrap_cyc.size() >= 2) chk("p1_wrap_period", wrap_cyc[1] - wrap_cyc[0], N * (RD_LAT + 3));
    chk("p1_no_valid", valid_cycles, 0);

    // single due slot, immediate accept
    quiesce();
    r5 = mk_rec(64'd100); r5[273:226] = 48'h1234_5678_9ABC;
    mem[5] = r5; SYS_TIME = 64'd100;
    n0 = hs_addr.size(); m0 = fr_addr.size();
    EN = 1'b1;
    wait_hs(n0 + 1, "t2_hs");
    wait_fr(m0 + 1, "t2_fr");
    tick(2);
    if (hs_addr.size() > n0) begin
      chk("t2_addr", hs_addr[n0], 5);
      chk("t2_data", hs_data[n0], r5);
    end
    if (fr_addr.size() > m0) chk("t2_free", fr_addr[m0], 5);
    chk("t2_cnt", ISSUE_CNT, 1);

    // not due on first scan, due after time advances; issued exactly once
    quiesce();
    mem[7] = mk_rec(64'd1000); SYS_TIME = 64'd999;
    n0 = hs_addr.size();
    EN = 1'b1;
    wait_wrap("t3_w0"); wait_wrap("t3_w1");
    chk("t3_skip", hs_addr.size(), n0);
    SYS_TIME = 64'd1000;
    wait_wrap("t3_w2"); wait_wrap("t3_w3");
    chk("t3_once", hs_addr.size(), n0 + 1);
    if (hs_addr.size() > n0) chk("t3_addr", hs_addr[n0], 7);

    // backpressure: hold for 20 cycles
    quiesce();
    r3 = mk_rec(64'd5); mem[3] = r3; rdy_pct = 0;
    n0 = hs_addr.size();
    EN = 1'b1;
    wait_valid(3, "t4_valid");
    for (int i = 0; i < 20; i++) begin
      chk("t4_hold_v", CMD_VALID, 1);
      chk("t4_hold_d", CMD_DATA, r3);
      tick(1);
    end
    rdy_pct = 100;
    wait_hs(n0 + 1, "t4_hs");
    tick(3);
    chk("t4_once", hs_addr.size(), n0 + 1);
    chk("t4_cnt", ISSUE_CNT, 16'(exp_cnt));

    // slow free ack with two consecutive due slots
    quiesce();
    ack_min = 10; ack_max = 10;
    mem[3] = mk_rec(64'd50); mem[4] = mk_rec(64'd60);
    n0 = hs_addr.size(); m0 = fr_addr.size(); f0 = free_cycles;
    EN = 1'b1;
    wait_fr(m0 + 2, "t5_fr");
    if (hs_addr.size() >= n0 + 2 && fr_addr.size() >= m0 + 2) begin
      chk("t5_hs0", hs_addr[n0], 3);     chk("t5_hs1", hs_addr[n0+1], 4);
      chk("t5_fr0", fr_addr[m0], 3);     chk("t5_fr1", fr_addr[m0+1], 4);
      chk("t5_order", hs_cyc[n0+1] > fr_cyc[m0], 1);
    end
    chk("t5_req_len", free_cycles - f0, 2 * (10 + 1));

    // reset while a command is pending
    quiesce();
    ack_min = 0; ack_max = 2;
    mem[9] = mk_rec(64'd7); rdy_pct = 0;
    n0 = hs_addr.size(); m0 = fr_addr.size();
    EN = 1'b1;
    wait_valid(9, "t6_valid");
    rst = 1'b1;
    tick(1);
    chk("t6_valid_drop", CMD_VALID, 0);
    chk("t6_rdaddr", MEM_RDADDR, 0);
    chk("t6_cnt_rst", ISSUE_CNT, 0);
    chk("t6_freereq", FREE_REQ, 0);
    rst = 1'b0; rdy_pct = 100;
    wait_hs(n0 + 1, "t6_hs");
    wait_fr(m0 + 1, "t6_fr");
    tick(2);
    chk("t6_once", hs_addr.size(), n0 + 1);
    if (hs_addr.size() > n0) chk("t6_addr", hs_addr[n0], 9);
    if (fr_addr.size() > m0) chk("t6_free", fr_addr[m0], 9);
    chk("t6_cnt", ISSUE_CNT, 1);

    // random fill, time, handshakes and enable
    quiesce();
    for (int i = 0; i < 40; i++) mem[$urandom_range(0, N-1)] = mk_rec(64'($urandom_range(0, 3000)));
    rdy_pct = 70; ack_min = 0; ack_max = 3; spurious = 1;
    n0 = hs_addr.size();
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) SYS_TIME = 64'($urandom_range(0, 3500));
      EN = ($urandom_range(0, 7) != 0);
      tick(1);
    end
    chk("t7_activity", hs_addr.size() > n0, 1);
    tick(1);
    chk("t7_cnt", ISSUE_CNT, 16'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
